// File: rtl/hack_sequencer.sv
// -----------------------------------------------------------------------------
// hack_sequencer
//
// Multi-cycle control unit for the Hack 16-bit CPU. It fetches an instruction,
// decodes it, and then runs it as one of two sequences:
//   A-instruction : FETCH -> DECODE
//   C-instruction : FETCH -> DECODE -> [MEM_RD] -> EXEC -> [MEM_WR] -> COMMIT
// It owns all architectural state (A, D, PC) and the internal IR, M latch,
// result and flag registers. The ALU itself is external and combinational.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   instr_req/ack    instruction fetch handshake; instr_addr = PC
//   instr_data       instruction word, captured at the instr_ack edge
//   mem_req/ack      data-memory handshake; mem_we selects write (1) / read (0)
//   mem_addr         A[14:0] as it was when the instruction started
//   mem_wdata        stored ALU result (RES register)
//   mem_rdata        read data, captured at the mem_ack edge of a read
//   alu_x/alu_y      ALU operands: D, and M latch or A depending on IR[12]
//   alu_ctl          IR[11:6] = {zx,nx,zy,ny,f,no}, passed through unmodified
//   alu_out/zr/ng    ALU result and flags, sampled only at the EXEC edge
//   pc               current program counter
//   instr_done       one-cycle pulse in the cycle an instruction commits
// -----------------------------------------------------------------------------
module hack_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        instr_req,
  output logic [14:0] instr_addr,
  input  logic        instr_ack,
  input  logic [15:0] instr_data,
  // data memory
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  // ALU
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctl,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  // status
  output logic [14:0] pc,
  output logic        instr_done
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_MEM_RD = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM_WR = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]  state_reg, state_next;
  logic [15:0] ir_reg,    ir_next;
  logic [15:0] a_reg,     a_next;
  logic [15:0] d_reg,     d_next;
  logic [15:0] m_reg,     m_next;
  logic [15:0] res_reg,   res_next;
  logic        zr_reg,    zr_next;
  logic        ng_reg,    ng_next;
  logic [14:0] pc_reg,    pc_next;

  // ---------------------------------------------------------------------------
  // Instruction field decode (all from IR, stable for the whole instruction)
  // ---------------------------------------------------------------------------
  logic        is_c_instr;
  logic        sel_m;
  logic        dest_a;
  logic        dest_d;
  logic        dest_m;
  logic        jmp_lt;
  logic        jmp_eq;
  logic        jmp_gt;
  logic        take_jump;
  logic [14:0] pc_inc;

  assign is_c_instr = ir_reg[15];
  assign sel_m      = ir_reg[12];
  assign dest_a     = ir_reg[5];
  assign dest_d     = ir_reg[4];
  assign dest_m     = ir_reg[3];
  assign jmp_lt     = ir_reg[2];
  assign jmp_eq     = ir_reg[1];
  assign jmp_gt     = ir_reg[0];

  // The jump decision uses the flags latched at EXEC, never the live ALU
  // outputs, so the ALU inputs are free to change after EXEC.
  assign take_jump = (jmp_lt & ng_reg) |
                     (jmp_eq & zr_reg) |
                     (jmp_gt & ~zr_reg & ~ng_reg);

  // 15-bit add wraps 0x7FFF -> 0x0000 naturally.
  assign pc_inc = pc_reg + 15'd1;

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    a_next     = a_reg;
    d_next     = d_reg;
    m_next     = m_reg;
    res_next   = res_reg;
    zr_next    = zr_reg;
    ng_next    = ng_reg;
    pc_next    = pc_reg;

    case (state_reg)
      ST_FETCH: begin
        if (instr_ack) begin
          ir_next    = instr_data;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (!is_c_instr) begin
          // A-instruction completes here: load the 15-bit constant (IR[15]=0).
          a_next     = ir_reg;
          pc_next    = pc_inc;
          state_next = ST_FETCH;
        end else if (sel_m) begin
          state_next = ST_MEM_RD;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_MEM_RD: begin
        if (mem_ack) begin
          m_next     = mem_rdata;
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        res_next   = alu_out;
        zr_next    = alu_zr;
        ng_next    = alu_ng;
        state_next = dest_m ? ST_MEM_WR : ST_COMMIT;
      end

      ST_MEM_WR: begin
        if (mem_ack) begin
          state_next = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        if (dest_a) begin
          a_next = res_reg;
        end
        if (dest_d) begin
          d_next = res_reg;
        end
        // Jump target is the A value from before this commit, truncated.
        pc_next    = take_jump ? a_reg[14:0] : pc_inc;
        state_next = ST_FETCH;
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
      ir_reg    <= 16'h0000;
      a_reg     <= 16'h0000;
      d_reg     <= 16'h0000;
      m_reg     <= 16'h0000;
      res_reg   <= 16'h0000;
      zr_reg    <= 1'b0;
      ng_reg    <= 1'b0;
      pc_reg    <= 15'h0000;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
      a_reg     <= a_next;
      d_reg     <= d_next;
      m_reg     <= m_next;
      res_reg   <= res_next;
      zr_reg    <= zr_next;
      ng_reg    <= ng_next;
      pc_reg    <= pc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded directly from state and registers
  // ---------------------------------------------------------------------------
  // Reset parks the FSM in FETCH, so the fetch request is additionally gated by
  // rst_n: it stays low during reset and rises as soon as reset is released.
  assign instr_req  = rst_n & (state_reg == ST_FETCH);
  assign instr_addr = pc_reg;

  assign mem_req    = (state_reg == ST_MEM_RD) | (state_reg == ST_MEM_WR);
  assign mem_we     = (state_reg == ST_MEM_WR);
  // A is only updated at the end of an instruction, so A[14:0] is still the
  // value from instruction start throughout MEM_RD and MEM_WR.
  assign mem_addr   = a_reg[14:0];
  assign mem_wdata  = res_reg;

  assign alu_x      = d_reg;
  assign alu_y      = sel_m ? m_reg : a_reg;
  assign alu_ctl    = ir_reg[11:6];

  assign pc         = pc_reg;
  assign instr_done = ((state_reg == ST_DECODE) & ~is_c_instr) |
                      (state_reg == ST_COMMIT);

endmodule

// File: tb/tb_hack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hack_sequencer
//
// Directed bench for hack_sequencer. A per-cycle responder (task step) plays
// instruction memory and data memory with programmable wait states, and a
// reference Hack ALU is modelled combinationally. Each test task loads a few
// instructions, runs them and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_hack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req;
  logic [14:0] instr_addr;
  logic        instr_ack = 1'b0;
  logic [15:0] instr_data = 16'h0000;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [14:0] pc;
  logic        instr_done;

  always #5 clk = ~clk;

  hack_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .instr_data (instr_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_ctl    (alu_ctl),
    .alu_out    (alu_out),
    .alu_zr     (alu_zr),
    .alu_ng     (alu_ng),
    .pc         (pc),
    .instr_done (instr_done)
  );

  // Reference Hack ALU.
  always_comb begin
    logic [15:0] xa;
    logic [15:0] ya;
    logic [15:0] r;
    xa = alu_ctl[5] ? 16'h0000 : alu_x;
    if (alu_ctl[4]) xa = ~xa;
    ya = alu_ctl[3] ? 16'h0000 : alu_y;
    if (alu_ctl[2]) ya = ~ya;
    r = alu_ctl[1] ? (xa + ya) : (xa & ya);
    if (alu_ctl[0]) r = ~r;
    alu_out = r;
    alu_zr  = (r == 16'h0000);
    alu_ng  = r[15];
  end

  // Memories and responder state.
  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];
  int          wait_i = 0;
  int          wait_m = 0;
  int          icnt = 0;
  int          mcnt = 0;
  int          unstable = 0;
  int          n_reads = 0;
  int          n_writes = 0;
  logic        spur = 1'b0;
  logic [14:0] held_iaddr = '0;
  logic [14:0] held_maddr = '0;
  logic        held_we = 1'b0;
  logic [15:0] held_wdata = '0;
  logic [14:0] rd_addr = '0;
  logic [14:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        done_now = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  // One clock cycle of memory responder. Entered after a rising edge, decides
  // the acks at the falling edge and returns 1 time unit after the next rise.
  task automatic step();
    @(negedge clk);
    if (instr_req) begin
      if (icnt == 0) held_iaddr = instr_addr;
      else if (instr_addr !== held_iaddr) unstable++;
      if (icnt >= wait_i) begin
        instr_ack  = 1'b1;
        instr_data = imem[instr_addr];
        icnt       = 0;
      end else begin
        instr_ack  = 1'b0;
        instr_data = 16'h0BAD;
        icnt++;
      end
    end else begin
      instr_ack  = spur;
      instr_data = 16'h0BAD;
    end

    if (mem_req) begin
      if (mcnt == 0) begin
        held_maddr = mem_addr;
        held_we    = mem_we;
        held_wdata = mem_wdata;
      end else if (mem_addr !== held_maddr || mem_we !== held_we ||
                   (mem_we && mem_wdata !== held_wdata)) begin
        unstable++;
      end
      if (mcnt >= wait_m) begin
        mem_ack = 1'b1;
        mcnt    = 0;
        if (mem_we) begin
          wr_addr = mem_addr;
          wr_data = mem_wdata;
          dmem[mem_addr] = mem_wdata;
          n_writes++;
          mem_rdata = 16'hBEEF;
        end else begin
          rd_addr   = mem_addr;
          mem_rdata = dmem[mem_addr];
          n_reads++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'hBEEF;
        mcnt++;
      end
    end else begin
      mem_ack   = spur;
      mem_rdata = 16'hBEEF;
    end

    done_now = instr_done;
    @(posedge clk);
    #1;
  endtask

  // Runs until instr_done has been seen; cyc counts cycles including that one.
  task automatic run_instr(output int cyc);
    logic [14:0] start_pc;
    start_pc = pc;
    cyc      = 0;
    done_now = 1'b0;
    while (!done_now && cyc < 200) begin
      step();
      cyc++;
    end
    n_checks++;
    if (!done_now) begin
      n_fails++;
      $display("FAIL instr_timeout: got no instr_done in %0d cycles, required within 200", cyc);
    end
    $display("instr @%h word=%h cycles=%0d -> pc=%h A=%h D=%h",
             start_pc, imem[start_pc], cyc, pc, mem_addr, alu_x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({instr_req, mem_req, mem_we, instr_done} !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_ctrl: got req/mreq/we/done=%b required 0000",
               {instr_req, mem_req, mem_we, instr_done});
    end
    n_checks++;
    if (pc !== 15'h0000 || instr_addr !== 15'h0000 || mem_addr !== 15'h0000) begin
      n_fails++;
      $display("FAIL reset_addr: got pc=%h iaddr=%h maddr=%h required 0000", pc, instr_addr, mem_addr);
    end
    n_checks++;
    if (alu_x !== 16'h0 || alu_y !== 16'h0 || alu_ctl !== 6'h0 || mem_wdata !== 16'h0) begin
      n_fails++;
      $display("FAIL reset_data: got x=%h y=%h ctl=%h wdata=%h required 0", alu_x, alu_y, alu_ctl, mem_wdata);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (instr_req !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_release_req: got instr_req=%b required 1", instr_req);
    end
  endtask

  task automatic test_a_instr();
    int cyc;
    imem[0] = 16'h0005;
    run_instr(cyc);
    n_checks++;
    if (cyc !== 2) begin
      n_fails++;
      $display("FAIL a_instr_latency: got %0d cycles required 2", cyc);
    end
    n_checks++;
    if (mem_addr !== 15'h0005 || pc !== 15'h0001) begin
      n_fails++;
      $display("FAIL a_instr_state: got A=%h pc=%h required A=0005 pc=0001", mem_addr, pc);
    end
  endtask

  task automatic test_c_alu();
    int cyc;
    imem[1] = 16'hEC10;   // D=A
    imem[2] = 16'hE090;   // D=D+A
    run_instr(cyc);
    n_checks++;
    if (cyc !== 4 || alu_x !== 16'h0005) begin
      n_fails++;
      $display("FAIL c_d_eq_a: got cycles=%0d D=%h required 4 / 0005", cyc, alu_x);
    end
    run_instr(cyc);
    n_checks++;
    if (cyc !== 4 || alu_x !== 16'h000A || pc !== 15'h0003) begin
      n_fails++;
      $display("FAIL c_d_plus_a: got cycles=%0d D=%h pc=%h required 4 / 000a / 0003", cyc, alu_x, pc);
    end
  endtask

  task automatic test_mem_rmw();
    int cyc;
    imem[3] = 16'h0010;   // @16
    imem[4] = 16'hFDC8;   // M=M+1
    imem[5] = 16'hFDE8;   // AM=M+1
    dmem[16] = 16'h0007;
    n_reads = 0;
    n_writes = 0;
    run_instr(cyc);
    run_instr(cyc);
    n_checks++;
    if (cyc !== 6) begin
      n_fails++;
      $display("FAIL rmw_latency: got %0d cycles required 6", cyc);
    end
    n_checks++;
    if (n_reads !== 1 || rd_addr !== 15'h0010 || n_writes !== 1) begin
      n_fails++;
      $display("FAIL rmw_accesses: got reads=%0d raddr=%h writes=%0d required 1 / 0010 / 1",
               n_reads, rd_addr, n_writes);
    end
    n_checks++;
    if (wr_addr !== 15'h0010 || wr_data !== 16'h0008) begin
      n_fails++;
      $display("FAIL rmw_write: got addr=%h data=%h required 0010 / 0008", wr_addr, wr_data);
    end
    run_instr(cyc);
    n_checks++;
    if (wr_addr !== 15'h0010 || wr_data !== 16'h0009 || mem_addr !== 15'h0009 || pc !== 15'h0006) begin
      n_fails++;
      $display("FAIL am_write_old_addr: got waddr=%h wdata=%h A=%h pc=%h required 0010 / 0009 / 0009 / 0006",
               wr_addr, wr_data, mem_addr, pc);
    end
  endtask

  task automatic test_jump();
    int cyc;
    imem[6]     = 16'h0000;   // @0
    imem[7]     = 16'hEC10;   // D=A
    imem[8]     = 16'h0123;   // @0x123
    imem[9]     = 16'hE302;   // D;JEQ
    imem[16'h0123] = 16'hEFD0;   // D=1
    imem[16'h0124] = 16'hE302;   // D;JEQ (not taken)
    imem[16'h0125] = 16'hEE90;   // D=-1
    imem[16'h0126] = 16'hE304;   // D;JLT
    repeat (4) run_instr(cyc);
    n_checks++;
    if (pc !== 15'h0123 || cyc !== 4) begin
      n_fails++;
      $display("FAIL jeq_taken: got pc=%h cycles=%0d required 0123 / 4", pc, cyc);
    end
    run_instr(cyc);
    run_instr(cyc);
    n_checks++;
    if (pc !== 15'h0125) begin
      n_fails++;
      $display("FAIL jeq_not_taken: got pc=%h required 0125", pc);
    end
    run_instr(cyc);
    n_checks++;
    if (alu_x !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL d_minus_one: got D=%h required ffff", alu_x);
    end
    run_instr(cyc);
    n_checks++;
    if (pc !== 15'h0123) begin
      n_fails++;
      $display("FAIL jlt_taken: got pc=%h required 0123", pc);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    imem[16'h0123] = 16'hEEA0;   // A=-1
    imem[16'h0124] = 16'hEA87;   // 0;JMP
    imem[16'h7FFF] = 16'h0042;   // @0x42 at the top of memory
    run_instr(cyc);
    n_checks++;
    if (alu_y !== 16'hFFFF || mem_addr !== 15'h7FFF) begin
      n_fails++;
      $display("FAIL a_minus_one: got A=%h maddr=%h required ffff / 7fff", alu_y, mem_addr);
    end
    run_instr(cyc);
    n_checks++;
    if (pc !== 15'h7FFF) begin
      n_fails++;
      $display("FAIL jmp_truncate: got pc=%h required 7fff", pc);
    end
    run_instr(cyc);
    n_checks++;
    if (pc !== 15'h0000 || mem_addr !== 15'h0042) begin
      n_fails++;
      $display("FAIL pc_wrap: got pc=%h A=%h required 0000 / 0042", pc, mem_addr);
    end
  endtask

  task automatic test_waits();
    int cyc;
    imem[0]  = 16'hFDC8;   // M=M+1 at A=0x42
    dmem[66] = 16'h1234;
    wait_i   = 3;
    wait_m   = 3;
    spur     = 1'b1;
    unstable = 0;
    n_reads  = 0;
    n_writes = 0;
    run_instr(cyc);
    n_checks++;
    if (cyc !== 15) begin
      n_fails++;
      $display("FAIL wait_latency: got %0d cycles required 15", cyc);
    end
    n_checks++;
    if (unstable !== 0) begin
      n_fails++;
      $display("FAIL wait_stability: got %0d unstable cycles required 0", unstable);
    end
    n_checks++;
    if (wr_addr !== 15'h0042 || wr_data !== 16'h1235 || n_reads !== 1 || n_writes !== 1) begin
      n_fails++;
      $display("FAIL wait_capture: got waddr=%h wdata=%h reads=%0d writes=%0d required 0042 / 1235 / 1 / 1",
               wr_addr, wr_data, n_reads, n_writes);
    end
    n_checks++;
    if (alu_x !== 16'hFFFF || pc !== 15'h0001) begin
      n_fails++;
      $display("FAIL wait_regs: got D=%h pc=%h required ffff / 0001", alu_x, pc);
    end
    wait_i = 0;
    wait_m = 0;
    spur   = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    imem[1]  = 16'hE308;   // M=D
    wait_m   = 5;
    n_writes = 0;
    cyc      = 0;
    while (!(mem_req && mem_we) && cyc < 50) begin
      step();
      cyc++;
    end
    n_checks++;
    if (!(mem_req && mem_we)) begin
      n_fails++;
      $display("FAIL mid_reach_wr: got no write request in %0d cycles, required within 50", cyc);
    end
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({instr_req, mem_req, mem_we} !== 3'b000 || pc !== 15'h0000) begin
      n_fails++;
      $display("FAIL mid_async_drop: got req/mreq/we=%b pc=%h required 000 / 0000",
               {instr_req, mem_req, mem_we}, pc);
    end
    icnt      = 0;
    mcnt      = 0;
    instr_ack = 1'b0;
    mem_ack   = 1'b0;
    wait_m    = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (instr_req !== 1'b1 || instr_addr !== 15'h0000 || n_writes !== 0) begin
      n_fails++;
      $display("FAIL mid_restart: got req=%b iaddr=%h writes=%0d required 1 / 0000 / 0",
               instr_req, instr_addr, n_writes);
    end
    n_checks++;
    if (alu_x !== 16'h0000 || alu_y !== 16'h0000 || mem_addr !== 15'h0000) begin
      n_fails++;
      $display("FAIL mid_regs_clear: got D=%h A=%h maddr=%h required 0",
               alu_x, alu_y, mem_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end
    test_reset();
    test_a_instr();
    test_c_alu();
    test_mem_rmw();
    test_jump();
    test_wrap();
    test_waits();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog in case a stall escapes the per-wait bounds.
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, required finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
